// File: rtl/vx_scoreboard.sv
// Register-hazard scoreboard: holds off issue while any source/dest register of the warp has a write in flight.
// Latency: accepted instruction appears on out_* one cycle after in_valid & in_ready.
// Backpressure: in_ready drops on a hazard or when the output register is full and out_ready is low.
module vx_scoreboard #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 64,
    parameter int XLEN        = 32,
    parameter int UUID_W      = 44,
    parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NR_BITS     = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   in_valid,
    input  logic [UUID_W-1:0]      in_uuid,
    input  logic [NW_BITS-1:0]     in_wid,
    input  logic [NUM_THREADS-1:0] in_tmask,
    input  logic [XLEN-1:0]        in_PC,
    input  logic                   in_wb,
    input  logic [NR_BITS-1:0]     in_rd,
    input  logic [NR_BITS-1:0]     in_rs1,
    input  logic [NR_BITS-1:0]     in_rs2,
    input  logic [NR_BITS-1:0]     in_rs3,
    output logic                   in_ready,

    output logic                   out_valid,
    output logic [UUID_W-1:0]      out_uuid,
    output logic [NW_BITS-1:0]     out_wid,
    output logic [NUM_THREADS-1:0] out_tmask,
    output logic [XLEN-1:0]        out_PC,
    output logic                   out_wb,
    output logic [NR_BITS-1:0]     out_rd,
    input  logic                   out_ready,

    input  logic                   wb_valid,
    input  logic [NW_BITS-1:0]     wb_wid,
    input  logic [NR_BITS-1:0]     wb_rd,
    input  logic                   wb_eop,

    output logic [63:0]            perf_stalls
);

    // Payload carried from issue to dispatch.
    typedef struct packed {
        logic [UUID_W-1:0]      uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        pc;
        logic                   wb;
        logic [NR_BITS-1:0]     rd;
    } instr_t;

    typedef logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend_t;

    pend_t  pending_q, pending_d, pending_eff;
    instr_t out_q, out_d, in_pkt;
    logic   out_valid_q, out_valid_d;
    logic [63:0] stalls_q, stalls_d;

    logic clr;
    logic hazard;
    logic stage_free;
    logic fire;
    logic set_rd;

    assign in_pkt = '{uuid: in_uuid, wid: in_wid, tmask: in_tmask,
                      pc: in_PC, wb: in_wb, rd: in_rd};

    // Only the final writeback packet of an instruction retires its destination.
    assign clr = wb_valid & wb_eop;

    // Apply this cycle's writeback before hazard lookup so a retiring register
    // does not cost an extra stall cycle; r0 is hardwired and never pending.
    always_comb begin
        pending_eff = pending_q;
        if (clr) begin
            pending_eff[wb_wid][wb_rd] = 1'b0;
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_eff[w][0] = 1'b0;
        end
    end

    // Hazard lookup on the issuing warp's row only; warps are independent.
    always_comb begin
        hazard = pending_eff[in_wid][in_rs1]
               | pending_eff[in_wid][in_rs2]
               | pending_eff[in_wid][in_rs3]
               | (in_wb & pending_eff[in_wid][in_rd]);
    end

    assign stage_free = ~out_valid_q | out_ready;
    assign in_ready   = ~hazard & stage_free;
    assign fire       = in_valid & in_ready;
    assign set_rd     = fire & in_wb & (in_rd != '0);

    // Next pending state: clear first, then set, so a same-cycle set wins.
    always_comb begin
        pending_d = pending_eff;
        if (set_rd) begin
            pending_d[in_wid][in_rd] = 1'b1;
        end
    end

    // Output register: load on accept, drain when dispatch takes it, else hold.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (fire) begin
            out_d       = in_pkt;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Stall counter: cycles an instruction is presented but blocked by a hazard.
    always_comb begin
        stalls_d = stalls_q;
        if (in_valid & hazard) begin
            stalls_d = stalls_q + 64'd1;
        end
    end

    // State registers; reset drops any in-flight instruction immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stalls_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stalls_q    <= stalls_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_uuid    = out_q.uuid;
    assign out_wid     = out_q.wid;
    assign out_tmask   = out_q.tmask;
    assign out_PC      = out_q.pc;
    assign out_wb      = out_q.wb;
    assign out_rd      = out_q.rd;
    assign perf_stalls = stalls_q;

endmodule

// File: doc/vx_scoreboard.md
Name: VX_scoreboard

Overview:
Register-hazard scoreboard on the slave side of the issue-to-scoreboard handshake. It keeps one pending-write bit per architectural register per warp. An incoming instruction is held off until none of its source or destination registers is pending. Accepted instructions go through a one-entry output register toward dispatch. Writeback commits clear the pending bits.

Parameters:
NUM_WARPS, 4, warps tracked; NW_BITS = max(1, clog2(NUM_WARPS))
NUM_THREADS, 4, width of thread mask
NUM_REGS, 64, registers per warp (int + fp); NR_BITS = clog2(NUM_REGS)
XLEN, 32, PC width
UUID_W, 44, instruction uuid width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid from ibuffer
in_uuid  in  UUID_W  instruction uuid
in_wid  in  NW_BITS  warp id
in_tmask  in  NUM_THREADS  thread mask
in_PC  in  XLEN  program counter
in_wb  in  1  instruction writes rd
in_rd  in  NR_BITS  destination register
in_rs1 / in_rs2 / in_rs3  in  NR_BITS each  source registers
in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
out_valid  out  1  registered instruction valid toward dispatch
out_uuid, out_wid, out_tmask, out_PC, out_wb, out_rd  out  as inputs  registered copies
out_ready  in  1  dispatch accepts out_* when out_valid & out_ready
wb_valid  in  1  writeback commit valid
wb_wid  in  NW_BITS  writeback warp
wb_rd  in  NR_BITS  writeback register
wb_eop  in  1  last packet of the instruction's writeback; clears only when set
perf_stalls  out  64  count of cycles with in_valid & hazard

Behaviour:
- Reset (reset_n low, async): all pending bits 0, out_valid 0, out_* data 0, perf_stalls 0, in_ready reflects reset state (out stage empty).
- pending[w][r]: NUM_WARPS x NUM_REGS flop array.
- clr = wb_valid & wb_eop. clear vector = one-hot(wb_rd) for warp wb_wid.
- pending_eff = pending with the same-cycle clear applied (writeback bypass).
- hazard = pending_eff[in_wid][in_rs1] | [in_rs2] | [in_rs3] | (in_wb & [in_rd]). Register index 0 never reads as pending.
- stage_free = ~out_valid | out_ready.
- in_ready = ~hazard & stage_free. in_ready is combinational from in_* and wb_*; in_valid is not used in its computation.
- fire = in_valid & in_ready.
  - out_* loads the in_* fields; out_valid <= 1.
  - If in_wb and in_rd != 0, set pending[in_wid][in_rd].
- No fire and out_ready: out_valid <= 0. Output data holds while out_valid & ~out_ready.
- Latency: accepted instruction appears on out_* the next cycle. Full throughput is one per cycle when there are no hazards and out_ready is held high.
- Simultaneous set and clear of the same (warp, reg): set wins. Final state is pending.
- Simultaneous set and clear of different regs/warps: both apply.
- Clear of a register that is not pending: no effect. No error is raised.
- wb_valid with wb_eop = 0: no state change.
- perf_stalls increments by 1 each cycle in_valid & hazard. It wraps at 2^64.
- Handshake rules:
  - out_* stable while out_valid & ~out_ready.
  - The ibuffer holds in_* stable while in_valid & ~in_ready.
- Reset asserted mid-operation: all state clears immediately. Any in-flight out_* instruction is dropped.

Test Plan:
- Reset release, in_valid=1, w0 rd=5 rs1=1 rs2=2 rs3=0 wb=1, out_ready=1 -> in_ready=1 in cycle 0; out_valid=1 with rd=5 in cycle 1; pending[0][5]=1.
- Follow-up w0 rs1=5 -> in_ready=0, perf_stalls increments each cycle. Then wb_valid=1 wb_wid=0 wb_rd=5 wb_eop=1 -> in_ready=1 in the same cycle (bypass); pending[0][5] clears.
- w0 rd=5 pending, new w1 rs1=5 -> accepted immediately, because warps are independent.
- Back-to-back independent instructions with out_ready low for 3 cycles -> first held on out_*, in_ready=0 during the stall, no loss or duplication once out_ready rises.
- Same-cycle clear of w2 r7 and fire of w2 rd=7 wb=1 -> pending[2][7]=1 afterwards (set wins).
- rd=0 wb=1 issued, then rs1=0 reader -> never stalls; wb_eop=0 writeback of a pending reg -> bit stays set.
